mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares the single-ported unified instruction/data memory of the multicycle MIPS datapath between the instruction-fetch requester and the load/store requester. It owns the memory's address, write-data and write-enable lines, serialises accesses through a three-state FSM, and returns registered read data with a one-cycle ack per transaction. It sits between the control unit/PC logic and the memory.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter_pick.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
//   - default address/data widths
//   - FSM state encoding (ST_IDLE, ST_ACCESS, ST_RESP)
//   - requester identity (OWN_I = fetch, OWN_D = load/store)
//   - other_owner(): the requester that is not the given one
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_AW = 32;
    localparam int unsigned MEM_ARB_DW = 32;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_ACCESS = 2'd1;
    localparam arb_state_t ST_RESP   = 2'd2;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t own);
        return (own == OWN_D) ? OWN_I : OWN_D;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the requester handshakes and the memory port.
//   Fetch side : i_req, i_addr (in)  / i_ack, i_rdata (out)
//   Data side  : d_req, d_we, d_addr, d_wdata (in) / d_ack, d_rdata (out)
//   Memory side: mem_addr, mem_wdata, mem_we (out) / mem_rdata (in)
//   Status     : busy (out)
// Directions above are as seen by the arbiter (modport slave); modport master
// is the requester/memory environment view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_we, busy
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner selection for the memory port.
//   i_fetch_req  : fetch requester wants the port
//   i_data_req   : data requester wants the port
//   i_in_resp    : arbiter is in RESP; the current owner is excluded
//   i_owner      : current owner (meaningful in RESP)
//   i_last_owner : requester served last (only with MEM_ARB_RR_EN)
//   o_grant      : a requester is granted
//   o_grant_own  : which requester is granted
// Config macro: MEM_ARB_RR_EN selects round-robin on contention; otherwise
// data always beats fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_fetch_req,
    input  logic   i_data_req,
    input  logic   i_in_resp,
    input  owner_t i_owner,
`ifdef MEM_ARB_RR_EN
    input  owner_t i_last_owner,
`endif
    output logic   o_grant,
    output owner_t o_grant_own
);

    always_comb begin
        o_grant     = 1'b0;
        o_grant_own = OWN_D;
        if (i_in_resp) begin
            // The owner's req is still high by protocol; only the other side can win.
            if (i_owner == OWN_D) begin
                o_grant     = i_fetch_req;
                o_grant_own = OWN_I;
            end else begin
                o_grant     = i_data_req;
                o_grant_own = OWN_D;
            end
        end else if (i_fetch_req && i_data_req) begin
            o_grant = 1'b1;
`ifdef MEM_ARB_RR_EN
            o_grant_own = other_owner(i_last_owner);
`else
            o_grant_own = OWN_D;
`endif
        end else if (i_data_req) begin
            o_grant     = 1'b1;
            o_grant_own = OWN_D;
        end else if (i_fetch_req) begin
            o_grant     = 1'b1;
            o_grant_own = OWN_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported unified instruction/data memory
// between the fetch requester and the load/store requester.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (fetch/data handshakes, memory port, busy)
// Each transaction: IDLE/RESP grant -> ACCESS (memory driven one cycle) ->
// RESP (one-cycle ack, registered read data).
// Config macro: MEM_ARB_RR_EN (round-robin on contention, see mem_arb_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = MEM_ARB_AW,
    parameter int unsigned DW = MEM_ARB_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    arb_state_t    r_state,     w_state_nxt;
    owner_t        r_owner,     w_owner_nxt;
    logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic          r_mem_we,    w_mem_we_nxt;
    logic          r_i_ack,     w_i_ack_nxt;
    logic          r_d_ack,     w_d_ack_nxt;
    logic [DW-1:0] r_i_rdata,   w_i_rdata_nxt;
    logic [DW-1:0] r_d_rdata,   w_d_rdata_nxt;

    logic          w_in_resp;
    logic          w_grant;
    owner_t        w_grant_own;

    assign w_in_resp = (r_state == ST_RESP);

    // The owner register doubles as the last-served flag: it is only rewritten
    // on a grant and resets to data.
    mem_arb_pick u_pick (
        .i_fetch_req  (bus.i_req),
        .i_data_req   (bus.d_req),
        .i_in_resp    (w_in_resp),
        .i_owner      (r_owner),
`ifdef MEM_ARB_RR_EN
        .i_last_owner (r_owner),
`endif
        .o_grant      (w_grant),
        .o_grant_own  (w_grant_own)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_we_nxt    = r_mem_we;
        w_i_ack_nxt     = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_i_rdata_nxt   = r_i_rdata;
        w_d_rdata_nxt   = r_d_rdata;

        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_grant) begin
                    w_state_nxt = ST_ACCESS;
                    w_owner_nxt = w_grant_own;
                    if (w_grant_own == OWN_D) begin
                        w_mem_addr_nxt  = bus.d_addr;
                        w_mem_wdata_nxt = bus.d_wdata;
                        w_mem_we_nxt    = bus.d_we;
                    end else begin
                        w_mem_addr_nxt = bus.i_addr;
                        w_mem_we_nxt   = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                w_state_nxt  = ST_RESP;
                w_mem_we_nxt = 1'b0;
                if (r_owner == OWN_I) begin
                    w_i_ack_nxt   = 1'b1;
                    w_i_rdata_nxt = bus.mem_rdata;
                end else begin
                    w_d_ack_nxt = 1'b1;
                    // Stores leave the load data register untouched.
                    if (!r_mem_we) begin
                        w_d_rdata_nxt = bus.mem_rdata;
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_mem_we_nxt = 1'b0;
            end
        endcase
    end

    // Async reset drops mem_we immediately, so a store caught in ACCESS never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_D;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_i_ack     <= w_i_ack_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.i_ack     = r_i_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.busy      = (r_state != ST_IDLE);

    // Request payload must stay put while the request is outstanding.
    a_i_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.i_req && $past(bus.i_req) && !bus.i_ack && !$past(bus.i_ack))
            |-> $stable(bus.i_addr));

    a_d_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.d_req && $past(bus.d_req) && !bus.d_ack && !$past(bus.d_ack))
            |-> $stable({bus.d_we, bus.d_addr, bus.d_wdata}));

    a_one_ack: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.i_ack && bus.d_ack));

    a_ack_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.i_ack || bus.d_ack) |-> (r_state == ST_RESP));

    a_we_owner: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_we |-> (r_state == ST_ACCESS && r_owner == OWN_D));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Bench-side memory: combinational read, write at rising edge.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pre_we   = 1'b0;
    logic [7:0]  pre_addr = 8'h0;
    logic [31:0] pre_data = 32'h0;

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        ref_mem[a] = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        preload(8'h10, 32'h2008_0005);
        preload(8'h20, 32'h1111_1111);
        preload(8'h08, 32'hA5A5_5A5A);
        for (int a = 0; a < 16; a++) preload(8'h80 + 8'(a), $urandom);
        checks++;
        if ({bus.i_ack, bus.d_ack} !== 2'b00) begin
            errors++; $display("FAIL reset_acks: got %b exp 00", {bus.i_ack, bus.d_ack});
        end
        checks++;
        if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h exp 0", {bus.i_rdata, bus.d_rdata});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_we} !== 65'h0) begin
            errors++;
            $display("FAIL reset_mem: got addr %h wdata %h we %b exp 0",
                     bus.mem_addr, bus.mem_wdata, bus.mem_we);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.i_ack, bus.d_ack} !== 3'b000) begin
            errors++; $display("FAIL idle_after_reset: got %b exp 000",
                               {bus.busy, bus.i_ack, bus.d_ack});
        end
    endtask

    task automatic test_lone_fetch;
        int we_cnt = 0;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        tick();
        we_cnt += int'(bus.mem_we);
        checks++;
        if ({bus.mem_addr, bus.busy, bus.i_ack} !== {32'h10, 1'b1, 1'b0}) begin
            errors++; $display("FAIL fetch_access: got addr %h busy %b ack %b exp 10 1 0",
                               bus.mem_addr, bus.busy, bus.i_ack);
        end
        tick();
        we_cnt += int'(bus.mem_we);
        checks++;
        if ({bus.i_ack, bus.d_ack} !== 2'b10) begin
            errors++; $display("FAIL fetch_ack: got %b exp 10", {bus.i_ack, bus.d_ack});
        end
        checks++;
        if (bus.i_rdata !== 32'h2008_0005) begin
            errors++; $display("FAIL fetch_rdata: got %h exp 20080005", bus.i_rdata);
        end
        bus.i_req = 1'b0;
        tick();
        we_cnt += int'(bus.mem_we);
        checks++;
        if ({bus.i_ack, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL fetch_done: got %b exp 00", {bus.i_ack, bus.busy});
        end
        checks++;
        if (we_cnt !== 0) begin
            errors++; $display("FAIL fetch_no_we: got %0d exp 0", we_cnt);
        end
    endtask

    task automatic test_store_load;
        int we_cnt = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        we_cnt += int'(bus.mem_we);
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== {32'h40, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL store_access: got %h %h exp 40 deadbeef",
                               bus.mem_addr, bus.mem_wdata);
        end
        tick();
        we_cnt += int'(bus.mem_we);
        checks++;
        if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL store_ack: got ack %b rdata %h exp 1 0",
                               bus.d_ack, bus.d_rdata);
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        we_cnt += int'(bus.mem_we);
        checks++;
        if (we_cnt !== 1) begin
            errors++; $display("FAIL store_we_cycles: got %0d exp 1", we_cnt);
        end
        bus.d_req = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL load_rdata: got ack %b rdata %h exp 1 deadbeef",
                               bus.d_ack, bus.d_rdata);
        end
        checks++;
        if (bus.i_rdata !== 32'h2008_0005) begin
            errors++; $display("FAIL load_i_rdata_kept: got %h exp 20080005", bus.i_rdata);
        end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_contention;
        // Last served requester was data, so round-robin favours fetch here.
        owner_t      first   = RR_EN ? OWN_I : OWN_D;
        logic [1:0]  ack1    = (first == OWN_I) ? 2'b10 : 2'b01;
        logic [31:0] addr1   = (first == OWN_I) ? 32'h20 : 32'h40;
        logic [31:0] addr2   = (first == OWN_I) ? 32'h40 : 32'h20;
        bus.i_req = 1'b1; bus.i_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        tick();
        checks++;
        if ({bus.busy, bus.mem_addr} !== {1'b1, addr1}) begin
            errors++; $display("FAIL cont_first_grant: got busy %b addr %h exp 1 %h",
                               bus.busy, bus.mem_addr, addr1);
        end
        tick();
        checks++;
        if ({bus.i_ack, bus.d_ack} !== ack1) begin
            errors++; $display("FAIL cont_first_ack: got %b exp %b", {bus.i_ack, bus.d_ack}, ack1);
        end
        if (first == OWN_I) bus.i_req = 1'b0;
        else bus.d_req = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.i_ack, bus.d_ack, bus.mem_addr} !== {3'b100, addr2}) begin
            errors++; $display("FAIL cont_no_gap: got busy %b acks %b addr %h exp 1 00 %h",
                               bus.busy, {bus.i_ack, bus.d_ack}, bus.mem_addr, addr2);
        end
        tick();
        checks++;
        if ({bus.i_ack, bus.d_ack} !== ~ack1) begin
            errors++; $display("FAIL cont_second_ack: got %b exp %b",
                               {bus.i_ack, bus.d_ack}, ~ack1);
        end
        checks++;
        if ({bus.i_rdata, bus.d_rdata} !== {32'h1111_1111, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL cont_rdata: got %h %h exp 11111111 deadbeef",
                               bus.i_rdata, bus.d_rdata);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL cont_idle: got %b exp 0", bus.busy);
        end
    endtask

    task automatic test_fetch_not_starved;
        int n   = 0;
        int exp = RR_EN ? 2 : 4;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        for (int c = 1; c <= 8 && n == 0; c++) begin
            tick();
            if (bus.i_ack) n = c;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        checks++;
        if (n !== exp) begin
            errors++; $display("FAIL fetch_wait_cycles: got %0d exp %0d", n, exp);
        end
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL starve_drain: got busy %b exp 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_store;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h08; bus.d_wdata = 32'h1234;
        tick();
        checks++;
        if (bus.mem_we !== 1'b1) begin
            errors++; $display("FAIL rst_store_we: got %b exp 1", bus.mem_we);
        end
        #2;
        rst_n = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        #1;
        checks++;
        if ({bus.mem_we, bus.busy, bus.i_ack, bus.d_ack, bus.mem_addr, bus.mem_wdata,
             bus.i_rdata, bus.d_rdata} !== '0) begin
            errors++; $display("FAIL rst_async_clear: got we %b busy %b addr %h rdata %h",
                               bus.mem_we, bus.busy, bus.mem_addr, bus.i_rdata);
        end
        tick();
        checks++;
        if (mem[8'h08] !== 32'hA5A5_5A5A) begin
            errors++; $display("FAIL rst_store_suppressed: got %h exp a5a55a5a", mem[8'h08]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.d_ack, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL rst_no_ack: got %b exp 00", {bus.d_ack, bus.busy});
        end
    endtask

    task automatic test_random_protocol;
        arb_state_t  m_state = ST_IDLE;
        owner_t      m_owner = OWN_D;
        logic        pend_i = 1'b0, pend_d = 1'b0;
        logic        s_ir, s_dr, exp_i, exp_d;
        int          issued = 0, acked = 0, cyc = 0;
        logic [7:0]  ia = 8'h80, da = 8'h80;
        logic        dwe = 1'b0;
        logic [31:0] dwd = 32'h0;
        while ((issued < 1000 || pend_i || pend_d) && cyc < 10000) begin
            s_ir = bus.i_req;
            s_dr = bus.d_req;
            @(posedge clk);
            cyc++;
            case (m_state)
                ST_IDLE: begin
                    if (s_ir || s_dr) begin
                        if (s_ir && s_dr) m_owner = RR_EN ? other_owner(m_owner) : OWN_D;
                        else m_owner = s_dr ? OWN_D : OWN_I;
                        m_state = ST_ACCESS;
                    end
                end
                ST_ACCESS: m_state = ST_RESP;
                default: begin
                    if ((m_owner == OWN_D) ? s_ir : s_dr) begin
                        m_owner = other_owner(m_owner);
                        m_state = ST_ACCESS;
                    end else begin
                        m_state = ST_IDLE;
                    end
                end
            endcase
            exp_i = (m_state == ST_RESP) && (m_owner == OWN_I);
            exp_d = (m_state == ST_RESP) && (m_owner == OWN_D);
            #1;
            checks++;
            if ({bus.busy, bus.i_ack, bus.d_ack} !== {m_state != ST_IDLE, exp_i, exp_d}) begin
                errors++; $display("FAIL rand_state cyc %0d: got busy/acks %b exp %b", cyc,
                                   {bus.busy, bus.i_ack, bus.d_ack},
                                   {m_state != ST_IDLE, exp_i, exp_d});
            end
            checks++;
            if (bus.i_ack && bus.d_ack) begin
                errors++; $display("FAIL rand_ack_excl cyc %0d: got both acks exp one", cyc);
            end
            if (bus.i_ack) begin
                checks++;
                if (bus.i_rdata !== ref_mem[ia]) begin
                    errors++; $display("FAIL rand_fetch_data cyc %0d: got %h exp %h",
                                       cyc, bus.i_rdata, ref_mem[ia]);
                end
                pend_i = 1'b0; bus.i_req = 1'b0; acked++;
            end
            if (bus.d_ack) begin
                if (dwe) begin
                    ref_mem[da] = dwd;
                end else begin
                    checks++;
                    if (bus.d_rdata !== ref_mem[da]) begin
                        errors++; $display("FAIL rand_load_data cyc %0d: got %h exp %h",
                                           cyc, bus.d_rdata, ref_mem[da]);
                    end
                end
                pend_d = 1'b0; bus.d_req = 1'b0; acked++;
            end
            if (!pend_i && issued < 1000 && $urandom_range(0, 2) == 0) begin
                ia = 8'h80 + 8'($urandom_range(0, 15));
                bus.i_addr = {24'h0, ia}; bus.i_req = 1'b1; pend_i = 1'b1; issued++;
            end
            if (!pend_d && issued < 1000 && $urandom_range(0, 2) == 0) begin
                da = 8'h80 + 8'($urandom_range(0, 15));
                dwe = 1'($urandom_range(0, 1));
                dwd = $urandom;
                bus.d_addr = {24'h0, da}; bus.d_we = dwe; bus.d_wdata = dwd;
                bus.d_req = 1'b1; pend_d = 1'b1; issued++;
            end
        end
        checks++;
        if ({pend_i, pend_d} !== 2'b00) begin
            errors++; $display("FAIL rand_timeout: pending %b after %0d cycles exp 00",
                               {pend_i, pend_d}, cyc);
        end
        checks++;
        if (acked !== issued) begin
            errors++; $display("FAIL rand_ack_count: got %0d acks exp %0d", acked, issued);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_contention();
        test_fetch_not_starved();
        test_reset_mid_store();
        test_random_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
